// File: rtl/sysram_portb_arbiter.sv
// Port B arbiter for the CPU system data RAM: PXIe write, UART write and C2H read.
// Priority build option: define SYSRAM_ARB_RR_EN for round-robin, otherwise fixed C2H > PXIE > UART.
module sysram_portb_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_pxie_wr_req,
    input  logic [ADDR_W-1:0] I_pxie_wr_addr,
    input  logic [DATA_W-1:0] I_pxie_wr_data,
    output logic              O_pxie_wr_ack,
    input  logic              I_uart_wr_req,
    input  logic [ADDR_W-1:0] I_uart_wr_addr,
    input  logic [DATA_W-1:0] I_uart_wr_data,
    output logic              O_uart_wr_ack,
    input  logic              I_c2h_rd_req,
    input  logic [ADDR_W-1:0] I_c2h_rd_addr,
    output logic              O_c2h_rd_ack,
    output logic [DATA_W-1:0] O_c2h_rd_data,
    output logic              O_c2h_rd_vld,
    output logic [ADDR_W-1:0] O_ram_addr,
    output logic [DATA_W-1:0] O_ram_din,
    output logic [3:0]        O_ram_wen,
    input  logic [DATA_W-1:0] I_ram_dout,
    output logic [2:0]        O_grant,
    output logic [15:0]       O_conflict_cnt
);
    // Requester vectors are ordered {UART, PXIE, C2H}.
    logic [2:0]        req;
    logic [2:0]        elig;
    logic [2:0]        gnt;
    logic [2:0]        ack_q, ack_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [3:0]        wen_q, wen_d;
    logic [2:0]        grant_q, grant_d;
    logic [RD_LAT:0]   rd_pipe_q, rd_pipe_d;
    logic              rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              contended;

    assign req  = {I_uart_wr_req, I_pxie_wr_req, I_c2h_rd_req};
    // A requester whose ack is high is still holding the req it was just served for.
    assign elig = req & ~ack_q;
    assign contended = (elig[0] & elig[1]) | (elig[0] & elig[2]) | (elig[1] & elig[2]);

`ifdef SYSRAM_ARB_RR_EN
    // ptr_q is the index searched first; it moves to the one after the last grant.
    logic [1:0] ptr_q, ptr_d;

    always_comb begin
        int idx;
        gnt   = 3'b000;
        ptr_d = ptr_q;
        for (int i = 0; i < 3; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= 3) idx = idx - 3;
            if (gnt == 3'b000 && elig[idx]) begin
                gnt[idx] = 1'b1;
                ptr_d    = (idx == 2) ? 2'd0 : 2'(idx + 1);
            end
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) ptr_q <= 2'd0;
        else       ptr_q <= ptr_d;
    end
`else
    always_comb begin
        gnt = 3'b000;
        if (elig[0])      gnt = 3'b001;
        else if (elig[1]) gnt = 3'b010;
        else if (elig[2]) gnt = 3'b100;
    end
`endif

    always_comb begin
        ack_d   = gnt;
        addr_d  = addr_q;
        din_d   = din_q;
        wen_d   = 4'h0;
        grant_d = grant_q;
        if (gnt[0]) begin
            addr_d = I_c2h_rd_addr;
        end else if (gnt[1]) begin
            addr_d = I_pxie_wr_addr;
            din_d  = I_pxie_wr_data;
            wen_d  = 4'hF;
        end else if (gnt[2]) begin
            addr_d = I_uart_wr_addr;
            din_d  = I_uart_wr_data;
            wen_d  = 4'hF;
        end
        if (gnt != 3'b000) grant_d = gnt;
    end

    // Read tag travels RD_LAT+1 stages so the capture lines up with RAM data valid.
    always_comb begin
        rd_pipe_d = {rd_pipe_q[RD_LAT-1:0], gnt[0]};
        rd_vld_d  = rd_pipe_q[RD_LAT];
        rd_data_d = rd_pipe_q[RD_LAT] ? I_ram_dout : rd_data_q;
        cnt_d     = cnt_q;
        if (contended && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            ack_q     <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            wen_q     <= '0;
            grant_q   <= '0;
            rd_pipe_q <= '0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            ack_q     <= ack_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            wen_q     <= wen_d;
            grant_q   <= grant_d;
            rd_pipe_q <= rd_pipe_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign O_c2h_rd_ack   = ack_q[0];
    assign O_pxie_wr_ack  = ack_q[1];
    assign O_uart_wr_ack  = ack_q[2];
    assign O_ram_addr     = addr_q;
    assign O_ram_din      = din_q;
    assign O_ram_wen      = wen_q;
    assign O_grant        = grant_q;
    assign O_c2h_rd_vld   = rd_vld_q;
    assign O_c2h_rd_data  = rd_data_q;
    assign O_conflict_cnt = cnt_q;
endmodule

// File: tb/tb_sysram_portb_arbiter.sv
// Directed bench for sysram_portb_arbiter with a fixed-latency read-only RAM model.
module tb_sysram_portb_arbiter;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              pxie_req, uart_req, c2h_req;
    logic [ADDR_W-1:0] pxie_addr, uart_addr, c2h_addr;
    logic [DATA_W-1:0] pxie_data, uart_data;
    logic              pxie_ack, uart_ack, c2h_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_vld;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [3:0]        ram_wen;
    logic [DATA_W-1:0] ram_dout;
    logic [2:0]        grant;
    logic [15:0]       conflict_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sysram_portb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .I_clk(clk), .I_rst(rst),
        .I_pxie_wr_req(pxie_req), .I_pxie_wr_addr(pxie_addr), .I_pxie_wr_data(pxie_data),
        .O_pxie_wr_ack(pxie_ack),
        .I_uart_wr_req(uart_req), .I_uart_wr_addr(uart_addr), .I_uart_wr_data(uart_data),
        .O_uart_wr_ack(uart_ack),
        .I_c2h_rd_req(c2h_req), .I_c2h_rd_addr(c2h_addr), .O_c2h_rd_ack(c2h_ack),
        .O_c2h_rd_data(rd_data), .O_c2h_rd_vld(rd_vld),
        .O_ram_addr(ram_addr), .O_ram_din(ram_din), .O_ram_wen(ram_wen),
        .I_ram_dout(ram_dout), .O_grant(grant), .O_conflict_cnt(conflict_cnt)
    );

    function automatic logic [31:0] exp_mem(input logic [15:0] a);
        return (a == 16'h0020) ? 32'h12345678 : (32'hA5000000 | {16'h0, a});
    endfunction

    // RAM port B read model: RD_LAT registered stages from address to dout.
    logic [DATA_W-1:0] rpipe [RD_LAT];
    always @(posedge clk) begin
        rpipe[0] <= exp_mem(ram_addr);
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_dout = rpipe[RD_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] exp_g;
        int nrd, issued;
        pxie_req = 0; uart_req = 0; c2h_req = 0;
        pxie_addr = 0; uart_addr = 0; c2h_addr = 0;
        pxie_data = 0; uart_data = 0;
        do_reset();

        chk("rst_acks", {29'd0, uart_ack, pxie_ack, c2h_ack}, 0);
        chk("rst_wen", {28'd0, ram_wen}, 0);
        chk("rst_addr", {16'd0, ram_addr}, 0);
        chk("rst_grant", {29'd0, grant}, 0);
        chk("rst_cnt", {16'd0, conflict_cnt}, 0);
        chk("rst_vld", {31'd0, rd_vld}, 0);

        // Single PXIe write, req held one cycle past ack
        pxie_addr = 16'h0010; pxie_data = 32'hDEADBEEF; pxie_req = 1;
        tick();
        chk("wr_ack", {31'd0, pxie_ack}, 1);
        chk("wr_addr", {16'd0, ram_addr}, 32'h0010);
        chk("wr_din", ram_din, 32'hDEADBEEF);
        chk("wr_wen", {28'd0, ram_wen}, 32'hF);
        chk("wr_grant", {29'd0, grant}, 32'b010);
        tick();
        chk("wr_ack_drop", {31'd0, pxie_ack}, 0);
        chk("wr_wen_drop", {28'd0, ram_wen}, 0);
        chk("wr_addr_hold", {16'd0, ram_addr}, 32'h0010);
        pxie_req = 0;

        // Single C2H read, vld exactly RD_LAT+1 after ack
        c2h_addr = 16'h0020; c2h_req = 1;
        tick();
        chk("rd_ack", {31'd0, c2h_ack}, 1);
        chk("rd_wen", {28'd0, ram_wen}, 0);
        chk("rd_din_hold", ram_din, 32'hDEADBEEF);
        chk("rd_grant", {29'd0, grant}, 32'b001);
        c2h_req = 0;
        for (int i = 1; i <= RD_LAT + 2; i++) begin
            tick();
            chk($sformatf("rd_vld_t%0d", i), {31'd0, rd_vld}, (i == RD_LAT + 1) ? 1 : 0);
            if (i == RD_LAT + 1) chk("rd_data", rd_data, 32'h12345678);
        end

        // Full contention for 12 cycles from a fresh pointer
        do_reset();
        pxie_addr = 16'h0040; pxie_data = 32'h11110000;
        uart_addr = 16'h0041; uart_data = 32'h22220000;
        c2h_addr  = 16'h0030;
        pxie_req = 1; uart_req = 1; c2h_req = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
`ifdef SYSRAM_ARB_RR_EN
            exp_g = (i % 3 == 0) ? 3'b001 : (i % 3 == 1) ? 3'b010 : 3'b100;
`else
            exp_g = (i % 2 == 0) ? 3'b001 : 3'b010;
`endif
            chk($sformatf("cont_grant_%0d", i), {29'd0, grant}, {29'd0, exp_g});
            chk($sformatf("cont_ack_%0d", i), {29'd0, uart_ack, pxie_ack, c2h_ack}, {29'd0, exp_g});
        end
        chk("cont_cnt", {16'd0, conflict_cnt}, 12);
        pxie_req = 0; uart_req = 0; c2h_req = 0;
        tick();
        chk("cont_cnt_idle", {16'd0, conflict_cnt}, 12);
        repeat (6) tick();

        // Back-to-back reads of 0..7
        c2h_addr = 0; c2h_req = 1; nrd = 0; issued = 0;
        for (int t = 0; t < 60 && nrd < 8; t++) begin
            tick();
            if (rd_vld) begin
                chk($sformatf("b2b_data_%0d", nrd), rd_data, exp_mem(16'(nrd)));
                nrd++;
            end
            if (c2h_ack) begin
                issued++;
                if (issued == 8) c2h_req = 0;
                else c2h_addr = 16'(issued);
            end
        end
        chk("b2b_count", nrd, 8);
        c2h_req = 0;
        repeat (4) tick();
        chk("b2b_no_extra", {31'd0, rd_vld}, 0);

        // Reset one cycle after a read ack
        c2h_addr = 16'h0003; c2h_req = 1;
        tick();
        chk("rr_ack", {31'd0, c2h_ack}, 1);
        c2h_req = 0;
        tick();
        rst = 1;
        pxie_addr = 16'h0055; pxie_data = 32'hCAFEF00D; pxie_req = 1;
        #1;
        chk("rr_acks0", {29'd0, uart_ack, pxie_ack, c2h_ack}, 0);
        chk("rr_wen0", {28'd0, ram_wen}, 0);
        chk("rr_addr0", {16'd0, ram_addr}, 0);
        chk("rr_din0", ram_din, 0);
        chk("rr_grant0", {29'd0, grant}, 0);
        chk("rr_data0", rd_data, 0);
        chk("rr_cnt0", {16'd0, conflict_cnt}, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rr_vld_in_rst_%0d", i), {31'd0, rd_vld}, 0);
        end
        rst = 0;
        tick();
        chk("rr_pxie_ack", {31'd0, pxie_ack}, 1);
        chk("rr_pxie_addr", {16'd0, ram_addr}, 32'h0055);
        pxie_req = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rr_vld_after_%0d", i), {31'd0, rd_vld}, 0);
        end

        // Conflict counter saturation
        do_reset();
        pxie_req = 1; uart_req = 1; c2h_req = 1;
        repeat (65534) tick();
        chk("sat_fffe", {16'd0, conflict_cnt}, 32'hFFFE);
        tick();
        chk("sat_ffff", {16'd0, conflict_cnt}, 32'hFFFF);
        repeat (70000 - 65535) tick();
        chk("sat_hold", {16'd0, conflict_cnt}, 32'hFFFF);
        pxie_req = 0; uart_req = 0; c2h_req = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
